dmem_responder: RTL and testbench

Synthesizable data-memory responder for the tagged-ticket bus driven by the dcache miss path. It accepts one BUS_LOAD or BUS_STORE per cycle and either refuses it or grants a 4-bit ticket in the same cycle. Accepted loads return their data a fixed number of cycles later, qualified by the same ticket on the tag output. It replaces the behavioural memory model behind the dcache, so dcache, dcachemem and the LSQ can be exercised against pipelined, back-pressured memory.

---
 rtl/dmem_responder_if.sv | 21 ++
 rtl/dmem_responder.sv | 81 ++++++++
 tb/tb_dmem_responder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Tagged-ticket bus between the dcache miss path (master) and the data memory (slave).
// mem2proc_response is combinational and grants or refuses the command in its own cycle;
// mem2proc_tag/mem2proc_data are registered and nonzero only in a load-return cycle.
interface dmem_responder_if;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [3:0]  mem2proc_tag;
  logic [63:0] mem2proc_data;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_response, mem2proc_tag, mem2proc_data
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_response, mem2proc_tag, mem2proc_data
  );
endinterface

// File: rtl/dmem_responder.sv
// Pipelined, back-pressured data memory: grants a ticket per accepted command and
// returns load data with that ticket a fixed MEM_LATENCY cycles after acceptance.
module dmem_responder #(
  parameter int MEM_LATENCY = 4,
  parameter int NUM_TICKETS = 15,
  parameter int ADDR_BITS   = 10
) (
  input  logic             clock,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  logic [63:0]          mem [2**ADDR_BITS];
  logic [NUM_TICKETS:1] busy;
  // Ticket 0 marks an empty stage; empty stages also hold zero data so the
  // last stage can drive the outputs directly.
  logic [3:0]           pipe_tag  [MEM_LATENCY];
  logic [63:0]          pipe_data [MEM_LATENCY];

  logic [ADDR_BITS-1:0] word_idx;
  logic [3:0]           free_ticket;
  logic [3:0]           ret_tag;
  logic                 cmd_valid;
  logic                 accept;
  logic                 grant_load;
  logic                 grant_store;
  logic                 unused_addr_bits;

  assign word_idx         = bus.proc2mem_addr[ADDR_BITS+2:3];
  assign unused_addr_bits = ^{bus.proc2mem_addr[63:ADDR_BITS+3], bus.proc2mem_addr[2:0]};

  always_comb begin
    free_ticket = '0;
    for (int i = NUM_TICKETS; i >= 1; i--) begin
      if (!busy[i]) free_ticket = 4'(i);
    end
  end

  assign cmd_valid   = (bus.proc2mem_command == BUS_LOAD) || (bus.proc2mem_command == BUS_STORE);
  assign accept      = cmd_valid && (free_ticket != 4'd0) && !reset;
  assign grant_load  = accept && (bus.proc2mem_command == BUS_LOAD);
  assign grant_store = accept && (bus.proc2mem_command == BUS_STORE);

  assign bus.mem2proc_response = accept ? free_ticket : 4'd0;

  assign ret_tag           = pipe_tag[MEM_LATENCY-1];
  assign bus.mem2proc_tag  = ret_tag;
  assign bus.mem2proc_data = pipe_data[MEM_LATENCY-1];

  // A returning ticket stays busy through its return cycle, so it can never be
  // re-granted in the same cycle it comes back.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
      for (int s = 0; s < MEM_LATENCY; s++) begin
        pipe_tag[s]  <= 4'd0;
        pipe_data[s] <= 64'd0;
      end
    end else begin
      for (int i = 1; i <= NUM_TICKETS; i++) begin
        busy[i] <= (busy[i] && (ret_tag != 4'(i))) ||
                   (grant_load && (free_ticket == 4'(i)));
      end
      pipe_tag[0]  <= grant_load ? free_ticket : 4'd0;
      pipe_data[0] <= grant_load ? mem[word_idx] : 64'd0;
      for (int s = 1; s < MEM_LATENCY; s++) begin
        pipe_tag[s]  <= pipe_tag[s-1];
        pipe_data[s] <= pipe_data[s-1];
      end
    end
  end

  // Array contents survive reset; loads snapshot the word before this write lands.
  always_ff @(posedge clock) begin
    if (grant_store) mem[word_idx] <= bus.proc2mem_data;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances cover the default, a
// two-ticket back-pressure configuration, and the single-cycle/single-ticket corner.
module tb_dmem_responder;

  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_STORE = 2'd2;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();
  dmem_responder_if bus_c ();

  dmem_responder #(.MEM_LATENCY(4), .NUM_TICKETS(15), .ADDR_BITS(10)) dut_a (
    .clock(clk), .reset(reset), .bus(bus_a)
  );
  dmem_responder #(.MEM_LATENCY(4), .NUM_TICKETS(2), .ADDR_BITS(10)) dut_b (
    .clock(clk), .reset(reset), .bus(bus_b)
  );
  dmem_responder #(.MEM_LATENCY(1), .NUM_TICKETS(1), .ADDR_BITS(10)) dut_c (
    .clock(clk), .reset(reset), .bus(bus_c)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  // One bus cycle on instance d: drive at posedge+1, sample at the negedge.
  task automatic step(input int d, input string name, input logic rst,
                      input logic [1:0] cmd, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [3:0] exp_resp, input logic [3:0] exp_tag,
                      input logic [63:0] exp_data);
    logic [3:0]  r;
    logic [3:0]  t;
    logic [63:0] dv;
    reset = rst;
    bus_a.proc2mem_command = C_NONE; bus_a.proc2mem_addr = '0; bus_a.proc2mem_data = '0;
    bus_b.proc2mem_command = C_NONE; bus_b.proc2mem_addr = '0; bus_b.proc2mem_data = '0;
    bus_c.proc2mem_command = C_NONE; bus_c.proc2mem_addr = '0; bus_c.proc2mem_data = '0;
    case (d)
      0: begin bus_a.proc2mem_command = cmd; bus_a.proc2mem_addr = addr; bus_a.proc2mem_data = wdata; end
      1: begin bus_b.proc2mem_command = cmd; bus_b.proc2mem_addr = addr; bus_b.proc2mem_data = wdata; end
      default: begin bus_c.proc2mem_command = cmd; bus_c.proc2mem_addr = addr; bus_c.proc2mem_data = wdata; end
    endcase
    @(negedge clk);
    case (d)
      0: begin r = bus_a.mem2proc_response; t = bus_a.mem2proc_tag; dv = bus_a.mem2proc_data; end
      1: begin r = bus_b.mem2proc_response; t = bus_b.mem2proc_tag; dv = bus_b.mem2proc_data; end
      default: begin r = bus_c.mem2proc_response; t = bus_c.mem2proc_tag; dv = bus_c.mem2proc_data; end
    endcase
    check($sformatf("%s resp", name), 64'(r), 64'(exp_resp));
    check($sformatf("%s tag", name), 64'(t), 64'(exp_tag));
    check($sformatf("%s data", name), dv, exp_data);
    @(posedge clk);
    #1;
  endtask

  logic [3:0] bp_resp [12];
  logic [3:0] bp_tag  [16];

  initial begin
    bp_resp = '{4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2};
    bp_tag  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0,
                4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2};
    reset = 1'b1;
    bus_a.proc2mem_command = C_NONE; bus_a.proc2mem_addr = '0; bus_a.proc2mem_data = '0;
    bus_b.proc2mem_command = C_NONE; bus_b.proc2mem_addr = '0; bus_b.proc2mem_data = '0;
    bus_c.proc2mem_command = C_NONE; bus_c.proc2mem_addr = '0; bus_c.proc2mem_data = '0;
    @(posedge clk);
    #1;

    // Reset state: commands refused while reset is high, outputs zero.
    step(0, "rst0", 1'b1, C_LOAD,  64'h28, 64'h0, 4'd0, 4'd0, 64'h0);
    step(0, "rst1", 1'b1, C_STORE, 64'h28, 64'h1, 4'd0, 4'd0, 64'h0);

    // Store then load.
    step(0, "sl_c0", 1'b0, C_STORE, 64'h28, 64'haaaaaaaaaaaaaaaa, 4'd1, 4'd0, 64'h0);
    step(0, "sl_c1", 1'b0, C_LOAD,  64'h28, 64'h0, 4'd1, 4'd0, 64'h0);
    step(0, "sl_c2", 1'b0, C_NONE,  64'h0,  64'h0, 4'd0, 4'd0, 64'h0);
    step(0, "sl_c3", 1'b0, C_NONE,  64'h0,  64'h0, 4'd0, 4'd0, 64'h0);
    step(0, "sl_c4", 1'b0, C_NONE,  64'h0,  64'h0, 4'd0, 4'd0, 64'h0);
    step(0, "sl_c5", 1'b0, C_NONE,  64'h0,  64'h0, 4'd0, 4'd1, 64'haaaaaaaaaaaaaaaa);
    step(0, "sl_c6", 1'b0, C_NONE,  64'h0,  64'h0, 4'd0, 4'd0, 64'h0);

    // Snapshot ordering: load before store sees the old value.
    step(0, "sn_c0", 1'b0, C_LOAD,  64'h40, 64'h0, 4'd1, 4'd0, 64'h0);
    step(0, "sn_c1", 1'b0, C_STORE, 64'h40, 64'h1212121212121212, 4'd2, 4'd0, 64'h0);
    step(0, "sn_c2", 1'b0, C_LOAD,  64'h40, 64'h0, 4'd2, 4'd0, 64'h0);
    step(0, "sn_c3", 1'b0, C_NONE,  64'h0,  64'h0, 4'd0, 4'd0, 64'h0);
    step(0, "sn_c4", 1'b0, C_NONE,  64'h0,  64'h0, 4'd0, 4'd1, 64'h0);
    step(0, "sn_c5", 1'b0, C_NONE,  64'h0,  64'h0, 4'd0, 4'd0, 64'h0);
    step(0, "sn_c6", 1'b0, C_NONE,  64'h0,  64'h0, 4'd0, 4'd2, 64'h1212121212121212);
    step(0, "sn_c7", 1'b0, C_NONE,  64'h0,  64'h0, 4'd0, 4'd0, 64'h0);

    // Aliasing: 0x2003 maps to word 0 with ADDR_BITS=10.
    step(0, "al_c0", 1'b0, C_STORE, 64'h2003, 64'h5, 4'd1, 4'd0, 64'h0);
    step(0, "al_c1", 1'b0, C_LOAD,  64'h0000, 64'h0, 4'd1, 4'd0, 64'h0);
    for (int c = 2; c < 5; c++)
      step(0, $sformatf("al_c%0d", c), 1'b0, C_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    step(0, "al_c5", 1'b0, C_NONE, 64'h0, 64'h0, 4'd0, 4'd1, 64'h5);

    // Reset mid-flight: in-flight tags vanish, stored data survives.
    step(0, "rm_c0", 1'b0, C_STORE, 64'h88, 64'h0123456789abcdef, 4'd1, 4'd0, 64'h0);
    step(0, "rm_c1", 1'b0, C_LOAD,  64'h88, 64'h0, 4'd1, 4'd0, 64'h0);
    step(0, "rm_c2", 1'b0, C_LOAD,  64'h10, 64'h0, 4'd2, 4'd0, 64'h0);
    step(0, "rm_c3", 1'b1, C_LOAD,  64'h88, 64'h0, 4'd0, 4'd0, 64'h0);
    step(0, "rm_c4", 1'b0, C_LOAD,  64'h88, 64'h0, 4'd1, 4'd0, 64'h0);
    for (int c = 5; c < 8; c++)
      step(0, $sformatf("rm_c%0d", c), 1'b0, C_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    step(0, "rm_c8", 1'b0, C_NONE, 64'h0, 64'h0, 4'd0, 4'd1, 64'h0123456789abcdef);
    step(0, "rm_c9", 1'b0, C_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);

    // Back-pressure with two tickets, a load every cycle, then drain.
    for (int c = 0; c < 16; c++) begin
      if (c < 12)
        step(1, $sformatf("bp_c%0d", c), 1'b0, C_LOAD, 64'(c * 8), 64'h0, bp_resp[c], bp_tag[c], 64'h0);
      else
        step(1, $sformatf("bp_c%0d", c), 1'b0, C_NONE, 64'h0, 64'h0, 4'd0, bp_tag[c], 64'h0);
    end

    // Stores are refused too while every ticket is busy.
    step(1, "bs_c0", 1'b0, C_LOAD,  64'h30, 64'h0, 4'd1, 4'd0, 64'h0);
    step(1, "bs_c1", 1'b0, C_LOAD,  64'h30, 64'h0, 4'd2, 4'd0, 64'h0);
    step(1, "bs_c2", 1'b0, C_STORE, 64'h30, 64'h99, 4'd0, 4'd0, 64'h0);
    step(1, "bs_c3", 1'b0, C_NONE,  64'h0,  64'h0, 4'd0, 4'd0, 64'h0);
    step(1, "bs_c4", 1'b0, C_NONE,  64'h0,  64'h0, 4'd0, 4'd1, 64'h0);
    step(1, "bs_c5", 1'b0, C_NONE,  64'h0,  64'h0, 4'd0, 4'd2, 64'h0);
    step(1, "bs_c6", 1'b0, C_LOAD,  64'h30, 64'h0, 4'd1, 4'd0, 64'h0);
    for (int c = 7; c < 10; c++)
      step(1, $sformatf("bs_c%0d", c), 1'b0, C_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    step(1, "bs_c10", 1'b0, C_NONE, 64'h0, 64'h0, 4'd0, 4'd1, 64'h0);

    // Latency 1, one ticket: grants alternate, each return one cycle later.
    for (int c = 0; c < 8; c++)
      step(2, $sformatf("l1_c%0d", c), 1'b0, C_LOAD, 64'h0, 64'h0,
           (c % 2 == 0) ? 4'd1 : 4'd0, (c % 2 == 1) ? 4'd1 : 4'd0, 64'h0);
    step(2, "l1_c8",  1'b0, C_NONE,  64'h0,  64'h0,  4'd0, 4'd0, 64'h0);
    step(2, "l1_c9",  1'b0, C_STORE, 64'h18, 64'h77, 4'd1, 4'd0, 64'h0);
    step(2, "l1_c10", 1'b0, C_LOAD,  64'h18, 64'h0,  4'd1, 4'd0, 64'h0);
    step(2, "l1_c11", 1'b0, C_NONE,  64'h0,  64'h0,  4'd0, 4'd1, 64'h77);
    step(2, "l1_c12", 1'b0, C_NONE,  64'h0,  64'h0,  4'd0, 4'd0, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
